// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
// The granted requester's access is performed during its gnt cycle; read data
// appears on the shared rdata register one cycle later with a per-port rvalid.
module ram_port_arbiter #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              gnt_a,
    output logic              rvalid_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_b,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              last_served;      // 0 = A, 1 = B
    logic              recent_b;         // most recent owner including the current cycle
    logic              acc_valid;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;

    logic [DATA_W-1:0] mem [DEPTH];

    // Next owner: single requester wins outright, a tie goes to whoever was not served last.
    always_comb begin
        state_next = IDLE;
        recent_b   = last_served;
        if (state == OWN_A) begin
            recent_b = 1'b0;
        end else if (state == OWN_B) begin
            recent_b = 1'b1;
        end
        if (req_a && req_b) begin
            state_next = recent_b ? OWN_A : OWN_B;
        end else if (req_a) begin
            state_next = OWN_A;
        end else if (req_b) begin
            state_next = OWN_B;
        end
    end

    // Memory access mux: the current owner's command drives the RAM.
    always_comb begin
        acc_valid = (state == OWN_A) || (state == OWN_B);
        acc_we    = we_a;
        acc_addr  = addr_a;
        acc_wdata = wdata_a;
        if (state == OWN_B) begin
            acc_we    = we_b;
            acc_addr  = addr_b;
            acc_wdata = wdata_b;
        end
    end

    // State register with registered grants and round-robin history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            gnt_a       <= 1'b0;
            gnt_b       <= 1'b0;
            last_served <= 1'b1;
        end else begin
            state       <= state_next;
            gnt_a       <= (state_next == OWN_A);
            gnt_b       <= (state_next == OWN_B);
            last_served <= recent_b;
        end
    end

    // RAM write port; contents survive reset but a write under reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && acc_valid && acc_we) begin
            mem[acc_addr] <= acc_wdata;
        end
    end

    // Registered read data and one-cycle read-valid pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata    <= '0;
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
        end else begin
            rvalid_a <= (state == OWN_A) && !we_a;
            rvalid_b <= (state == OWN_B) && !we_b;
            if (acc_valid && !acc_we) begin
                rdata <= mem[acc_addr];
            end
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus a random
// run, all compared against a transaction-level reference model.
module tb_ram_port_arbiter;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_a, we_a, req_b, we_b;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [DATA_W-1:0] wdata_a, wdata_b;
    logic              gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W+3:0] obs;

    int checks = 0;
    int failures = 0;

    // reference model: who owns the current cycle (0 none, 1 A, 2 B)
    int                m_owner;
    bit                m_last_b;
    logic [DATA_W-1:0] m_mem [64];
    logic [DATA_W-1:0] m_rdata;
    bit                m_rva, m_rvb;

    ram_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .gnt_a(gnt_a), .rvalid_a(rvalid_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_b(gnt_b), .rvalid_b(rvalid_b),
        .rdata(rdata)
    );

    always #5 clk = ~clk;

    assign obs = {gnt_a, gnt_b, rvalid_a, rvalid_b, rdata};

    function automatic logic [DATA_W+3:0] exp_vec();
        return {(m_owner == 1), (m_owner == 2), m_rva, m_rvb, m_rdata};
    endfunction

    // Apply one clock edge to the model using the inputs presented this cycle.
    task automatic model_edge();
        if (rst) begin
            m_owner  = 0;
            m_last_b = 1'b1;
            m_rva    = 1'b0;
            m_rvb    = 1'b0;
            m_rdata  = '0;
        end else begin
            m_rva = 1'b0;
            m_rvb = 1'b0;
            if (m_owner == 1) begin
                if (we_a) m_mem[addr_a] = wdata_a;
                else begin m_rdata = m_mem[addr_a]; m_rva = 1'b1; end
                m_last_b = 1'b0;
            end else if (m_owner == 2) begin
                if (we_b) m_mem[addr_b] = wdata_b;
                else begin m_rdata = m_mem[addr_b]; m_rvb = 1'b1; end
                m_last_b = 1'b1;
            end
            if (req_a && req_b) m_owner = m_last_b ? 1 : 2;
            else if (req_a)     m_owner = 1;
            else if (req_b)     m_owner = 2;
            else                m_owner = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_a = 0; req_b = 0; we_a = 0; we_b = 0;
        addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
        tick(); tick();
        checks++;
        if (obs !== exp_vec()) begin failures++; $display("FAIL reset_model obs=%h exp=%h", obs, exp_vec()); end
        checks++;
        if (obs !== 12'h000) begin failures++; $display("FAIL reset_zero obs=%h exp=000", obs); end
        rst = 1'b0;
    endtask

    task automatic test_fill();
        req_a = 1; we_a = 1; addr_a = '0; wdata_a = 8'($urandom);
        tick();
        checks++;
        if (obs !== exp_vec()) begin failures++; $display("FAIL fill_req obs=%h exp=%h", obs, exp_vec()); end
        for (int i = 0; i < 64; i++) begin
            addr_a = ADDR_W'(i); wdata_a = 8'($urandom); req_a = (i != 63);
            tick();
            checks++;
            if (obs !== exp_vec() || gnt_a !== (i != 63)) begin
                failures++; $display("FAIL fill[%0d] obs=%h exp=%h", i, obs, exp_vec());
            end
        end
        tick();
    endtask

    task automatic test_write_read();
        rst = 1; tick(); rst = 0;
        req_a = 1; we_a = 1; addr_a = 6'd5; wdata_a = 8'h3C;
        tick();
        checks++;
        if (gnt_a !== 1'b1 || obs !== exp_vec()) begin failures++; $display("FAIL wr_gnt obs=%h exp=%h", obs, exp_vec()); end
        req_a = 0;
        tick();
        checks++;
        if (obs !== exp_vec() || rvalid_a !== 1'b0) begin failures++; $display("FAIL wr_done obs=%h exp=%h", obs, exp_vec()); end
        req_a = 1; we_a = 0;
        tick();
        checks++;
        if (gnt_a !== 1'b1) begin failures++; $display("FAIL rd_gnt gnt_a=%b exp=1", gnt_a); end
        req_a = 0;
        tick();
        checks++;
        if (rvalid_a !== 1'b1 || rdata !== 8'h3C || obs !== exp_vec()) begin
            failures++; $display("FAIL rd_data rvalid_a=%b rdata=%h exp=1/3c", rvalid_a, rdata);
        end
        tick();
    endtask

    task automatic test_alternate();
        rst = 1; req_a = 1; req_b = 1; we_a = 0; we_b = 0;
        addr_a = 6'($urandom); addr_b = 6'($urandom);
        tick();
        rst = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec() || gnt_a !== (i % 2 == 0) || gnt_b !== (i % 2 == 1)
                || rvalid_a !== (i > 0 && i % 2 == 1) || rvalid_b !== (i > 0 && i % 2 == 0)) begin
                failures++; $display("FAIL alt[%0d] obs=%h exp=%h", i, obs, exp_vec());
            end
        end
        req_a = 0; req_b = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin failures++; $display("FAIL alt_drain[%0d] obs=%h exp=%h", i, obs, exp_vec()); end
        end
    endtask

    task automatic test_cross_port();
        req_b = 1; we_b = 1; addr_b = 6'd63; wdata_b = 8'h7F;
        tick();
        checks++;
        if (gnt_b !== 1'b1 || obs !== exp_vec()) begin failures++; $display("FAIL x_gnt_b obs=%h exp=%h", obs, exp_vec()); end
        req_b = 0; req_a = 1; we_a = 0; addr_a = 6'd63;
        tick();
        checks++;
        if (gnt_a !== 1'b1 || obs !== exp_vec()) begin failures++; $display("FAIL x_gnt_a obs=%h exp=%h", obs, exp_vec()); end
        req_a = 0;
        tick();
        checks++;
        if (rvalid_a !== 1'b1 || rdata !== 8'h7F || obs !== exp_vec()) begin
            failures++; $display("FAIL x_rdata rvalid_a=%b rdata=%h exp=1/7f", rvalid_a, rdata);
        end
        tick();
    endtask

    task automatic test_withdraw();
        logic [DATA_W-1:0] old;
        old = m_mem[20];
        rst = 1; req_a = 1; we_a = 0; addr_a = 6'd1;
        req_b = 1; we_b = 1; addr_b = 6'd20; wdata_b = ~old;
        tick();
        rst = 0;
        tick();
        checks++;
        if (gnt_a !== 1'b1 || gnt_b !== 1'b0 || obs !== exp_vec()) begin
            failures++; $display("FAIL wd_tie obs=%h exp=%h", obs, exp_vec());
        end
        req_b = 0;
        for (int i = 0; i < 3; i++) begin
            req_a = (i != 2);
            tick();
            checks++;
            if (gnt_b !== 1'b0 || obs !== exp_vec()) begin
                failures++; $display("FAIL wd_nognt[%0d] obs=%h exp=%h", i, obs, exp_vec());
            end
        end
        req_a = 1; we_a = 0; addr_a = 6'd20;
        tick();
        req_a = 0;
        tick();
        checks++;
        if (rvalid_a !== 1'b1 || rdata !== old || obs !== exp_vec()) begin
            failures++; $display("FAIL wd_mem rdata=%h exp=%h", rdata, old);
        end
        tick();
    endtask

    task automatic test_reset_during_write();
        req_a = 1; we_a = 1; addr_a = 6'd10; wdata_a = 8'h11;
        tick();
        req_a = 0;
        tick();
        req_a = 1; wdata_a = 8'h22;
        tick();
        rst = 1; req_a = 0;
        tick();
        checks++;
        if (obs !== 12'h000 || obs !== exp_vec()) begin failures++; $display("FAIL rstw_outs obs=%h exp=000", obs); end
        rst = 0;
        req_a = 1; we_a = 0;
        tick();
        req_a = 0;
        tick();
        checks++;
        if (rvalid_a !== 1'b1 || rdata !== 8'h11 || obs !== exp_vec()) begin
            failures++; $display("FAIL rstw_mem rdata=%h exp=11", rdata);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] prev;
        prev = m_rdata;
        req_a = 1; we_a = 1; addr_a = 6'd0; wdata_a = 8'hAA;
        tick();
        req_a = 0;
        tick();
        checks++;
        if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0 || rdata !== prev || obs !== exp_vec()) begin
            failures++; $display("FAIL wr_keep rdata=%h rv=%b%b exp=%h/00", rdata, rvalid_a, rvalid_b, prev);
        end
        req_b = 1; we_b = 0; addr_b = 6'($urandom);
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (gnt_b !== 1'b1 || obs !== exp_vec()) begin
                failures++; $display("FAIL stream[%0d] obs=%h exp=%h", i, obs, exp_vec());
            end
            addr_b = 6'($urandom); req_b = (i != 3);
            tick();
        end
        checks++;
        if (gnt_b !== 1'b0 || rvalid_b !== 1'b1 || obs !== exp_vec()) begin
            failures++; $display("FAIL stream_end obs=%h exp=%h", obs, exp_vec());
        end
        tick();
    endtask

    task automatic test_random();
        bit a_done = 0, b_done = 0;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            if (m_owner == 1) begin
                req_a = ($urandom_range(0, 3) != 0);
            end else if (!req_a || a_done) begin
                req_a = ($urandom_range(0, 2) != 0); we_a = ($urandom_range(0, 1) == 1);
                addr_a = 6'($urandom); wdata_a = 8'($urandom);
            end else if ($urandom_range(0, 9) == 0) begin
                req_a = 0;
            end
            if (m_owner == 2) begin
                req_b = ($urandom_range(0, 3) != 0);
            end else if (!req_b || b_done) begin
                req_b = ($urandom_range(0, 2) != 0); we_b = ($urandom_range(0, 1) == 1);
                addr_b = 6'($urandom); wdata_b = 8'($urandom);
            end else if ($urandom_range(0, 9) == 0) begin
                req_b = 0;
            end
            a_done = (m_owner == 1);
            b_done = (m_owner == 2);
            tick();
            checks++;
            if (obs !== exp_vec()) begin failures++; $display("FAIL rand[%0d] obs=%h exp=%h", i, obs, exp_vec()); end
        end
        rst = 0; req_a = 0; req_b = 0;
        tick(); tick();
        checks++;
        if (obs !== exp_vec()) begin failures++; $display("FAIL rand_drain obs=%h exp=%h", obs, exp_vec()); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_write_read();
        test_alternate();
        test_cross_port();
        test_withdraw();
        test_reset_during_write();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning memory word width.
REQ-002 The block SHALL have parameter ADDR_W, default 6, meaning address width; depth is 2**ADDR_W (64).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 The block SHALL have these ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- req_a  input  1  requester A access request
- we_a  input  1  A write enable (1 = write, 0 = read)
- addr_a  input  ADDR_W  A address
- wdata_a  input  DATA_W  A write data
- gnt_a  output  1  A grant; access is performed this cycle
- rvalid_a  output  1  rdata holds A's read result
- req_b, we_b, addr_b, wdata_b, gnt_b, rvalid_b  same as the A ports, for requester B
- rdata  output  DATA_W  shared read data, registered

Function
REQ-005 The block SHALL contain a 2**ADDR_W x DATA_W single-port memory; it performs at most one access per cycle.
REQ-006 The FSM SHALL have states IDLE, OWN_A and OWN_B; gnt_a = (state == OWN_A) and gnt_b = (state == OWN_B); both are registered and never both 1.
REQ-007 The next state SHALL be computed every cycle from req_a and req_b:
- neither asserted -> IDLE
- only one asserted -> that requester's OWN state
- both asserted -> the requester not served most recently (round-robin)
REQ-008 A 1-bit last_served register SHALL update to A or B on every clock edge that ends an OWN_A or OWN_B cycle.
REQ-009 During a cycle with gnt_x = 1, the memory access SHALL use that requester's we_x, addr_x and wdata_x as presented in that cycle; requesters hold these stable from req assertion through the gnt cycle.
REQ-010 A write SHALL commit at the clock edge ending the gnt cycle.
REQ-011 A read SHALL load rdata with mem[addr_x] at the edge ending the gnt cycle and pulse rvalid_x for exactly the following cycle; read latency is 1 cycle after gnt.
REQ-012 rdata SHALL hold its value until the next read; writes SHALL NOT change rdata or assert rvalid.
REQ-013 req_x still high at the edge ending a gnt_x cycle SHALL count as a new request; a requester wanting a single access deasserts req in its gnt cycle (req may depend combinationally on gnt).
REQ-014 A single continuous requester SHALL receive gnt every cycle, giving 1 access/cycle throughput.
REQ-015 Two continuous requesters SHALL alternate grants A,B,A,B with no idle cycles.
REQ-016 A write followed by a read of the same address in the next gnt cycle (either requester) SHALL return the newly written data.
REQ-017 req_x dropped before being granted SHALL withdraw the request; no access occurs and no state is retained for it.
REQ-018 Out-of-range addresses cannot occur; addresses SHALL wrap naturally at ADDR_W bits.

Reset
REQ-019 With rst = 1 at a rising edge, the block SHALL set state = IDLE, gnt_a = gnt_b = 0, rvalid_a = rvalid_b = 0, rdata = 0 and last_served = B, so A wins the first tie.
REQ-020 A write whose gnt cycle coincides with rst = 1 SHALL NOT commit, and a read in that cycle SHALL NOT produce rvalid.
REQ-021 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset, then req_a = 1 with we_a = 1, addr_a = 5, wdata_a = 0x3C for one grant, then a read of addr 5 -> gnt_a on the cycle after each request; rvalid_a one cycle after the read grant with rdata = 0x3C.
- req_a and req_b both held high from reset release, both reading -> grant order A,B,A,B; rvalid alternates a,b, each 1 cycle after its gnt.
- B writes 0x7F to addr 63, then A reads addr 63 in the next cycle -> rdata = 0x7F with rvalid_a.
- req_b asserted for 2 cycles, then dropped before its grant while A is being served -> gnt_b never asserts; memory unchanged.
- rst asserted during a gnt_a write cycle to addr 10 (prior value 0x11, new value 0x22) -> addr 10 reads back 0x11; all outputs 0 after the reset edge.
- A write of addr 0 with 0xAA -> rdata and rvalid unchanged; a single requester held high yields 4 grants in 4 consecutive cycles.
